maxpool_2x2: RTL



---
 rtl/maxpool_2x2_pkg.sv | 25 ++
 rtl/maxpool_2x2_if.sv | 32 +++
 rtl/maxpool_2x2_addr_gen.sv | 62 ++++++
 rtl/maxpool_2x2.sv | 138 +++++++++++++
 4 files changed

// File: rtl/maxpool_2x2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared types, FSM encoding and signed-max helper for maxpool_2x2.
// Revision : 1.0
// ============================================================================
package conv_pkg;

    localparam int DATA_W  = 8;
    localparam int WIN_CNT = 4;

    typedef logic signed [DATA_W-1:0] pix_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_LAST = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic pix_t smax(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool_2x2_if.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_2x2_if
// Brief    : Start/done handshake plus feature-RAM read and pooled-RAM write.
// Revision : 1.0
// ============================================================================
interface maxpool_2x2_if #(
    parameter int ADDR_LEN = 9
);
    import conv_pkg::*;

    logic              start;
    logic [ADDR_LEN:0] rd_addr;
    pix_t              rd_data;
    logic [ADDR_LEN:0] wr_addr;
    pix_t              wr_data;
    logic              wr_en;
    logic              busy;
    logic              done;

    modport master (
        input  start, rd_data,
        output rd_addr, wr_addr, wr_data, wr_en, busy, done
    );

    modport slave (
        output start, rd_data,
        input  rd_addr, wr_addr, wr_data, wr_en, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/maxpool_2x2_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : pool_addr_gen
// Brief    : Incremental window-base and pooled-address counters (no multipliers).
// Revision : 1.0
// ============================================================================
module pool_addr_gen #(
    parameter int H        = 26,
    parameter int W        = 26,
    parameter int ADDR_LEN = 9
) (
    input  wire                 clk,
    input  wire                 rst,
    input  wire                 clear,
    input  wire                 advance,
    output logic [ADDR_LEN:0]   base,
    output logic [ADDR_LEN:0]   wr_addr,
    output logic                last_pixel
);
    localparam int c_AW = ADDR_LEN + 1;
    localparam logic [ADDR_LEN:0] c_PH_M1    = c_AW'(H / 2 - 1);
    localparam logic [ADDR_LEN:0] c_PW_M1    = c_AW'(W / 2 - 1);
    localparam logic [ADDR_LEN:0] c_COL_STEP = c_AW'(2);
    // Lands on 2*(pr+1)*W: skips the odd row and any dropped last column.
    localparam logic [ADDR_LEN:0] c_ROW_STEP = c_AW'(2 * W - 2 * (W / 2) + 2);

    logic [ADDR_LEN:0] r_pr;
    logic [ADDR_LEN:0] r_pc;
    logic [ADDR_LEN:0] r_base;
    logic [ADDR_LEN:0] r_wr_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pr      <= '0;
            r_pc      <= '0;
            r_base    <= '0;
            r_wr_addr <= '0;
        end else if (clear) begin
            r_pr      <= '0;
            r_pc      <= '0;
            r_base    <= '0;
            r_wr_addr <= '0;
        end else if (advance) begin
            if (r_pc != c_PW_M1) begin
                r_pc      <= r_pc + 1'b1;
                r_base    <= r_base + c_COL_STEP;
                r_wr_addr <= r_wr_addr + 1'b1;
            end else if (r_pr != c_PH_M1) begin
                r_pc      <= '0;
                r_pr      <= r_pr + 1'b1;
                r_base    <= r_base + c_ROW_STEP;
                r_wr_addr <= r_wr_addr + 1'b1;
            end
        end
    end

    assign base       = r_base;
    assign wr_addr    = r_wr_addr;
    assign last_pixel = (r_pr == c_PH_M1) && (r_pc == c_PW_M1);

endmodule
`default_nettype wire

// File: rtl/maxpool_2x2.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_2x2
// Brief    : 2x2 stride-2 max-pool sequencer, feature RAM to pooled RAM, optional ReLU.
// Revision : 1.0
// ============================================================================
module maxpool_2x2
    import conv_pkg::*;
#(
    parameter int H        = 26,
    parameter int W        = 26,
    parameter int ADDR_LEN = 9,
    parameter int RELU     = 0
) (
    input  wire             clk,
    input  wire             rst,
    maxpool_2x2_if.master   bus
);
    localparam int c_AW = ADDR_LEN + 1;
    localparam logic [ADDR_LEN:0] c_OFF1 = c_AW'(1);
    localparam logic [ADDR_LEN:0] c_OFF2 = c_AW'(W);
    localparam logic [ADDR_LEN:0] c_OFF3 = c_AW'(W + 1);

    logic [2:0]        r_state;
    logic [1:0]        r_k;
    pix_t              r_max;
    logic [ADDR_LEN:0] r_rd_addr;
    logic [ADDR_LEN:0] r_wr_addr;
    pix_t              r_wr_data;
    logic              r_wr_en;
    logic              r_final;

    logic              w_clear;
    logic              w_advance;
    logic [ADDR_LEN:0] w_base;
    logic [ADDR_LEN:0] w_wr_addr;
    logic              w_last_pixel;
    logic [ADDR_LEN:0] w_off_next;
    pix_t              w_max_new;
    pix_t              w_pooled;

    assign w_clear   = (r_state == ST_IDLE) && bus.start;
    assign w_advance = (r_state == ST_LAST);

    pool_addr_gen #(
        .H        (H),
        .W        (W),
        .ADDR_LEN (ADDR_LEN)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_clear),
        .advance    (w_advance),
        .base       (w_base),
        .wr_addr    (w_wr_addr),
        .last_pixel (w_last_pixel)
    );

    // Offset of the address issued on the next edge while reading the window.
    always_comb begin
        w_off_next = c_OFF1;
        case (r_k)
            2'd0:    w_off_next = c_OFF1;
            2'd1:    w_off_next = c_OFF2;
            default: w_off_next = c_OFF3;
        endcase
    end

    assign w_max_new = smax(r_max, bus.rd_data);
    assign w_pooled  = ((RELU != 0) && w_max_new[DATA_W-1]) ? '0 : w_max_new;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_max     <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_en   <= 1'b0;
            r_final   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state   <= ST_RD;
                        r_k       <= '0;
                        r_rd_addr <= '0;
                    end
                end
                ST_RD: begin
                    r_k <= r_k + 2'd1;
                    if (r_k != 2'd3) begin
                        r_rd_addr <= w_base + w_off_next;
                    end
                    // rd_data lags rd_addr by one cycle, so k=1 sees datum 0.
                    if (r_k == 2'd1) begin
                        r_max <= bus.rd_data;
                    end else if (r_k != 2'd0) begin
                        r_max <= w_max_new;
                    end
                    if (r_k == 2'd3) begin
                        r_state <= ST_LAST;
                    end
                end
                ST_LAST: begin
                    r_max     <= w_max_new;
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_wr_addr;
                    r_wr_data <= w_pooled;
                    r_final   <= w_last_pixel;
                    r_state   <= ST_WR;
                end
                ST_WR: begin
                    r_wr_en   <= 1'b0;
                    r_k       <= '0;
                    r_rd_addr <= w_base;
                    r_state   <= r_final ? ST_DONE : ST_RD;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_addr = r_rd_addr;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.wr_en   = r_wr_en;
    assign bus.busy    = (r_state == ST_RD) || (r_state == ST_LAST) || (r_state == ST_WR);
    assign bus.done    = (r_state == ST_DONE);

endmodule
`default_nettype wire
